// File: rtl/add_seq_ctrl.sv
// Sequential WIDTH-bit adder: one SLICE-bit adder reused over WIDTH/SLICE cycles.
// Valid/ready on both sides; result registers hold until consumed.
module add_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [31:0]      base_d;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             c_sl;
  logic             last_sl;
  logic             ovf_d;

  // Shared slice adder working on the segment selected by the slice index
  always_comb begin
    base_d  = 32'(idx_q) * 32'(SLICE);
    a_sl    = a_q[base_d +: SLICE];
    b_sl    = b_q[base_d +: SLICE];
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl}
                 + {{SLICE{1'b0}}, carry_q};
    last_sl = (idx_q == IW'(N - 1));
    // Top slice MSB is being written this cycle, so use it directly
    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
           && (s_sl[SLICE-1] != a_q[WIDTH-1]);
  end

  // Control FSM plus operand, carry and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          sum_q[base_d +: SLICE] <= s_sl;
          carry_q <= c_sl;
          if (last_sl) begin
            cout_q      <= c_sl;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (WIDTH=64, SLICE=16).
// Vector table plus reset, backpressure and throughput sequences.
module tb_add_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  add_seq_ctrl #(.WIDTH(64), .SLICE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands for one accepting edge, then scramble the inputs
  task automatic start_op(input logic [63:0] ta, input logic [63:0] tb_,
                          input logic tc);
    @(negedge clk);
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
  endtask

  // Edges counted with the accepting edge as number 1
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_result(input logic [63:0] es);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_sum_hold", sum, es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [63:0] hold;
    logic [65:0] q [$];
    logic [65:0] e;
    logic [64:0] full;
    int cyc, last, got, pushed;

    vecs[0] = '{64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
                64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                64'h0, 1'b1, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      chk("calc_busy", 64'(busy), 64'd1);
      chk("calc_in_ready", 64'(in_ready), 64'd0);
      wait_valid(lat);
      chk("latency", 64'(lat), 64'd5);
      chk("vec_sum", sum, vecs[i].s);
      chk("vec_cout", 64'(cout), 64'(vecs[i].co));
      chk("vec_ovf", 64'(ovf), 64'(vecs[i].ov));
      take_result(vecs[i].s);
    end

    // Backpressure: result must hold while consumer stalls
    start_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'd5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = {$urandom, $urandom};
      @(posedge clk);
      #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", sum, 64'h0000_0001_0000_0000);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    take_result(64'h0000_0001_0000_0000);

    // Reset in the middle of CALC abandons the operation
    start_op(64'h5555_5555_5555_5555, 64'h1111_1111_1111_1111, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", sum, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hold = 64'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) hold = 64'd1;
    end
    chk("midrst_no_result", hold, 64'd0);

    // Accept on the very first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    a = 64'h0000_0000_0000_0003; b = 64'h4; cin = 1'b1;
    in_valid = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '1; b = '1; cin = 1'b0;
    chk("post_rst_accept", 64'(busy), 64'd1);
    wait_valid(lat);
    chk("post_rst_latency", 64'(lat), 64'd5);
    chk("post_rst_sum", sum, 64'h8);
    take_result(64'h8);

    // Throughput with both handshakes held high
    cyc = 0; last = -1; got = 0; pushed = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("tp_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("tp_sum", sum, e[63:0]);
          chk("tp_cout_ovf", {62'd0, ovf, cout}, {62'd0, e[65:64]});
        end
        got++;
      end
      if (in_ready && in_valid) begin
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        e = {(a[63] == b[63]) && (full[63] != a[63]), full[64],
             full[63:0]};
        q.push_back(e);
        if (last >= 0) chk("tp_spacing", 64'(cyc - last), 64'd6);
        last = cyc;
        pushed++;
        @(posedge clk);
        #1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        cin = 1'($urandom);
        if (pushed == 100) in_valid = 1'b0;
      end
    end
    chk("tp_results", 64'(got), 64'd100);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, total operand/sum width in bits.
REQ-002 SHALL have parameter SLICE, default 16, adder slice width processed per cycle; WIDTH SHALL be an integer multiple of SLICE and at least SLICE.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry-out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  signed (two's complement) overflow of the add.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL compute the WIDTH-bit add by time-multiplexing one SLICE-bit adder slice over N = WIDTH/SLICE cycles, least-significant slice first, with the inter-slice carry held in a register.
REQ-017 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on in_valid&in_ready; CALC->DONE after slice N-1; DONE->IDLE on out_ready; otherwise hold state.
REQ-018 SHALL drive in_ready = 1 only in IDLE; in_valid outside IDLE SHALL be ignored and operands SHALL not change.
REQ-019 SHALL capture a, b, cin into internal registers on the accepting edge; later input changes SHALL not affect the result.
REQ-020 SHALL keep a slice index counter, cleared to 0 on accept, incremented each CALC cycle, SLICE-bit segment k of sum written in the CALC cycle with index k.
REQ-021 SHALL seed the slice carry with captured cin; each CALC cycle SHALL update it with that slice's carry-out.
REQ-022 SHALL assert out_valid exactly N+1 rising edges after the accepting edge (first cycle in DONE) and hold sum, cout, ovf, out_valid stable until the out_ready handshake.
REQ-023 SHALL set cout to carry-out of slice N-1 and ovf to (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
REQ-024 SHALL drop out_valid on the edge where out_valid&out_ready; if out_ready already high on DONE entry, out_valid SHALL be high for exactly one cycle.
REQ-025 SHALL give minimum initiation interval N+2 cycles (accept, N CALC, DONE) with out_ready held high.
REQ-026 SHALL, for N=1 (WIDTH==SLICE), spend exactly one CALC cycle.
REQ-027 SHALL keep sum, cout, ovf holding the last completed result while in IDLE and CALC; only segment writes in CALC change sum bits.

Reset
REQ-028 SHALL on rst=1, asynchronously and regardless of state, force state IDLE, slice index 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, busy 0, in_ready 1 after release.
REQ-029 SHALL abandon an in-flight operation on reset mid-CALC or mid-DONE with no result delivered afterwards.
REQ-030 SHALL accept a new request on the first rising edge after rst deasserts if in_valid is high.

Verification
REQ-031 Reset: rst pulse while in CALC -> out_valid 0, sum 0, in_ready 1 immediately; no out_valid follows.
REQ-032 Basic: a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0001, cin=0 -> out_valid 5 edges after accept, sum=0x2, cout=0, ovf=0.
REQ-033 Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
REQ-034 Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-035 Backpressure: out_ready low 10 cycles in DONE -> sum/out_valid stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next edge.
REQ-036 Throughput: in_valid and out_ready held high, 100 random operands -> each result matches reference model, accepts spaced exactly 6 cycles.
